// File: rtl/bnn_img_pkg.sv
// Shared types, defaults and sizing helpers for the BNN image front-end.
package bnn_img_pkg;

   localparam int unsigned IMG_WIDTH_DEF  = 30;
   localparam int unsigned IMG_HEIGHT_DEF = 30;
   localparam int unsigned BYTE_W_DEF     = 8;

   typedef enum logic {EMPTY, FULL} bank_state_e;
   typedef enum logic {W_FILL, W_STALL} wr_state_e;

   function automatic int unsigned total_bits(int unsigned width, int unsigned height);
      return width * height;
   endfunction

   function automatic int unsigned num_words(int unsigned bits, int unsigned word_w);
      return (bits + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/image_bank.sv
// One frame of storage: NUM_WORDS x BYTE_W registers, single write port, full flat read.
module image_bank #(
   parameter int unsigned NUM_WORDS = 113,
   parameter int unsigned BYTE_W    = 8,
   parameter int unsigned CNT_W     = 7
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [CNT_W-1:0]              addr,
   input  logic [BYTE_W-1:0]             wdata,
   output logic [NUM_WORDS*BYTE_W-1:0]   rdata
);

   logic [NUM_WORDS-1:0][BYTE_W-1:0] mem_q;

   // Contents are intentionally not reset; validity is tracked by the owner.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q;

endmodule

// File: rtl/pingpong_image_buffer.sv
// Double-buffered frame store: one bank fills from the byte stream while the other is
// presented to the inference core until acknowledged.
module pingpong_image_buffer
   import bnn_img_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int unsigned BYTE_W     = BYTE_W_DEF,
   parameter bit          MSB_FIRST  = 1'b0,
   localparam int unsigned TOTAL_BITS = total_bits(IMG_WIDTH, IMG_HEIGHT),
   localparam int unsigned NUM_WORDS  = num_words(TOTAL_BITS, BYTE_W),
   localparam int unsigned CNT_W      = $clog2(NUM_WORDS + 1),
   localparam int unsigned IMG_W      = NUM_WORDS * BYTE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_buffer,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [CNT_W-1:0]  wr_count,
   output logic              frame_valid,
   input  logic              frame_ack,
   output logic [IMG_W-1:0]  img_out,
   output logic [1:0]        banks_full,
   output logic              overflow_err
);

   localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_WORDS - 1);
   localparam logic [IMG_W-1:0] ONE_W      = IMG_W'(1);
   localparam logic [IMG_W-1:0] VALID_MASK = (ONE_W << TOTAL_BITS) - ONE_W;

   bank_state_e      bank_q [2];
   bank_state_e      bank_d [2];
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [CNT_W-1:0] wr_count_q, wr_count_d;
   logic             overflow_q, overflow_d;
   wr_state_e        wr_state;
   logic             accept, ack;
   logic [BYTE_W-1:0] wdata;
   logic [IMG_W-1:0] bank_rdata [2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]  <= EMPTY;
         bank_q[1]  <= EMPTY;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_count_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_count_q <= wr_count_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      bank_d     = bank_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      wr_count_d = wr_count_q;
      overflow_d = overflow_q;
      wr_state   = (bank_q[wr_bank_q] == FULL) ? W_STALL : W_FILL;
      wr_ready   = (wr_state == W_FILL);
      accept     = wr_valid && wr_ready && !clear_buffer;
      ack        = frame_ack && (bank_q[rd_bank_q] == FULL) && !clear_buffer;

      if (clear_buffer) begin
         bank_d[0]  = EMPTY;
         bank_d[1]  = EMPTY;
         wr_bank_d  = 1'b0;
         rd_bank_d  = 1'b0;
         wr_count_d = '0;
         overflow_d = 1'b0;
      end else begin
         if (wr_valid && !wr_ready) begin
            overflow_d = 1'b1;
         end
         if (accept) begin
            if (wr_count_q == LAST_IDX) begin
               bank_d[wr_bank_q] = FULL;
               wr_count_d        = '0;
               wr_bank_d         = ~wr_bank_q;
            end else begin
               wr_count_d = wr_count_q + CNT_W'(1);
            end
         end
         // Ack always targets rd_bank, which is never the bank a write is completing.
         if (ack) begin
            bank_d[rd_bank_q] = EMPTY;
            rd_bank_d         = ~rd_bank_q;
         end
      end
   end

   always_comb begin
      wdata = data_in;
      if (MSB_FIRST) begin
         for (int b = 0; b < int'(BYTE_W); b++) begin
            wdata[b] = data_in[BYTE_W-1-b];
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      image_bank #(
         .NUM_WORDS (NUM_WORDS),
         .BYTE_W    (BYTE_W),
         .CNT_W     (CNT_W)
      ) u_bank (
         .clk   (clk),
         .we    (accept && (wr_bank_q == 1'(g))),
         .addr  (wr_count_q),
         .wdata (wdata),
         .rdata (bank_rdata[g])
      );
   end

   assign wr_count     = wr_count_q;
   assign banks_full   = {bank_q[1] == FULL, bank_q[0] == FULL};
   assign frame_valid  = (bank_q[rd_bank_q] == FULL);
   assign overflow_err = overflow_q;
   assign img_out      = (rd_bank_q ? bank_rdata[1] : bank_rdata[0]) & VALID_MASK;

endmodule

// File: tb/tb_pingpong_image_buffer.sv
// Directed bench for pingpong_image_buffer: default instance plus an MSB_FIRST instance.
module tb_pingpong_image_buffer;

   localparam int NW    = 113;
   localparam int IMG_W = NW * 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear_buffer;
   logic [7:0]       data_in;
   logic             wr_valid;
   logic             wr_ready;
   logic [6:0]       wr_count;
   logic             frame_valid;
   logic             frame_ack;
   logic [IMG_W-1:0] img_out;
   logic [1:0]       banks_full;
   logic             overflow_err;

   logic             b_clear;
   logic [7:0]       b_data;
   logic             b_valid;
   logic             b_ready;
   logic [6:0]       b_count;
   logic             b_frame_valid;
   logic             b_ack;
   logic [IMG_W-1:0] b_img;
   logic [1:0]       b_full;
   logic             b_ovf;

   int tests_run = 0;
   int tests_failed = 0;
   int ready_low = 0;

   always #5 clk = ~clk;

   pingpong_image_buffer u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_buffer (clear_buffer),
      .data_in      (data_in),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_count     (wr_count),
      .frame_valid  (frame_valid),
      .frame_ack    (frame_ack),
      .img_out      (img_out),
      .banks_full   (banks_full),
      .overflow_err (overflow_err)
   );

   pingpong_image_buffer #(.MSB_FIRST(1'b1)) u_dut_msb (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_buffer (b_clear),
      .data_in      (b_data),
      .wr_valid     (b_valid),
      .wr_ready     (b_ready),
      .wr_count     (b_count),
      .frame_valid  (b_frame_valid),
      .frame_ack    (b_ack),
      .img_out      (b_img),
      .banks_full   (b_full),
      .overflow_err (b_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word i carries (i + ad) ^ xr; optional ack raised alongside the final word.
   task automatic send(input int start, input int n, input logic [7:0] xr,
                       input logic [7:0] ad, input bit ack_last);
      for (int i = start; i < start + n; i++) begin
         data_in  = (8'(i) + ad) ^ xr;
         wr_valid = 1'b1;
         frame_ack = ack_last && (i == start + n - 1);
         if (wr_ready !== 1'b1) ready_low++;
         tick();
      end
      wr_valid  = 1'b0;
      frame_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_buffer = 1'b0; data_in = '0; wr_valid = 1'b0; frame_ack = 1'b0;
      b_clear = 1'b0; b_data = '0; b_valid = 1'b0; b_ack = 1'b0;
      #12;
      tests_run++;
      if ({wr_ready, frame_valid, banks_full, wr_count, overflow_err} !== {1'b1, 1'b0, 2'b00, 7'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_state: got rdy=%b fv=%b full=%b cnt=%0d ovf=%b, expected 1 0 00 0 0",
                  wr_ready, frame_valid, banks_full, wr_count, overflow_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_first_frame();
      ready_low = 0;
      send(0, NW - 1, 8'h00, 8'h00, 1'b0);
      tests_run++;
      if (frame_valid !== 1'b0 || wr_count !== 7'd112) begin
         tests_failed++;
         $display("FAIL pre_last_word: got fv=%b cnt=%0d, expected fv=0 cnt=112", frame_valid, wr_count);
      end
      send(NW - 1, 1, 8'h00, 8'h00, 1'b0);
      tests_run++;
      if (ready_low != 0) begin
         tests_failed++;
         $display("FAIL ready_during_fill: got %0d low cycles, expected 0", ready_low);
      end
      tests_run++;
      if (frame_valid !== 1'b1 || banks_full !== 2'b01 || wr_count !== 7'd0) begin
         tests_failed++;
         $display("FAIL frame0_done: got fv=%b full=%b cnt=%0d, expected 1 01 0", frame_valid, banks_full, wr_count);
      end
      tests_run++;
      if (img_out[7:0] !== 8'h00 || img_out[15:8] !== 8'h01 || img_out[407:400] !== 8'h32) begin
         tests_failed++;
         $display("FAIL frame0_words: got w0=%h w1=%h w50=%h, expected 00 01 32",
                  img_out[7:0], img_out[15:8], img_out[407:400]);
      end
      tests_run++;
      if (img_out[903:896] !== 8'h00) begin
         tests_failed++;
         $display("FAIL frame0_last_masked: got %h, expected 00", img_out[903:896]);
      end
   endtask

   task automatic test_overflow();
      send(0, NW, 8'hA5, 8'h00, 1'b0);
      tests_run++;
      if (wr_ready !== 1'b0 || banks_full !== 2'b11) begin
         tests_failed++;
         $display("FAIL both_full: got rdy=%b full=%b, expected 0 11", wr_ready, banks_full);
      end
      for (int i = 0; i < 5; i++) begin
         data_in = 8'hEE; wr_valid = 1'b1;
         tick();
      end
      wr_valid = 1'b0;
      tests_run++;
      if (overflow_err !== 1'b1 || wr_count !== 7'd0 || banks_full !== 2'b11 || wr_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL overflow: got ovf=%b cnt=%0d full=%b rdy=%b, expected 1 0 11 0",
                  overflow_err, wr_count, banks_full, wr_ready);
      end
      tests_run++;
      if (img_out[7:0] !== 8'h00 || img_out[47:40] !== 8'h05 || img_out[903:896] !== 8'h00) begin
         tests_failed++;
         $display("FAIL frame0_kept: got w0=%h w5=%h w112=%h, expected 00 05 00",
                  img_out[7:0], img_out[47:40], img_out[903:896]);
      end
   endtask

   task automatic test_ack_when_full();
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      tests_run++;
      if (frame_valid !== 1'b1 || wr_ready !== 1'b1 || banks_full !== 2'b10) begin
         tests_failed++;
         $display("FAIL ack_full: got fv=%b rdy=%b full=%b, expected 1 1 10", frame_valid, wr_ready, banks_full);
      end
      tests_run++;
      if (img_out[7:0] !== 8'hA5 || img_out[15:8] !== 8'hA4 || img_out[903:896] !== 8'h05) begin
         tests_failed++;
         $display("FAIL frame1_words: got w0=%h w1=%h w112=%h, expected a5 a4 05",
                  img_out[7:0], img_out[15:8], img_out[903:896]);
      end
   endtask

   task automatic test_ack_with_last();
      send(0, NW, 8'h00, 8'h03, 1'b1);
      tests_run++;
      if (frame_valid !== 1'b1 || banks_full !== 2'b01 || wr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL ack_with_last: got fv=%b full=%b rdy=%b, expected 1 01 1", frame_valid, banks_full, wr_ready);
      end
      tests_run++;
      if (img_out[7:0] !== 8'h03 || img_out[903:896] !== 8'h03 || overflow_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL frame2_words: got w0=%h w112=%h ovf=%b, expected 03 03 1",
                  img_out[7:0], img_out[903:896], overflow_err);
      end
   endtask

   task automatic test_clear();
      send(0, 50, 8'h00, 8'h00, 1'b0);
      tests_run++;
      if (wr_count !== 7'd50) begin
         tests_failed++;
         $display("FAIL partial_count: got %0d, expected 50", wr_count);
      end
      clear_buffer = 1'b1; wr_valid = 1'b1; frame_ack = 1'b1; data_in = 8'h77;
      tick();
      clear_buffer = 1'b0; wr_valid = 1'b0; frame_ack = 1'b0;
      tests_run++;
      if ({wr_count, banks_full, overflow_err, frame_valid, wr_ready} !== {7'd0, 2'b00, 1'b0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL clear: got cnt=%0d full=%b ovf=%b fv=%b rdy=%b, expected 0 00 0 0 1",
                  wr_count, banks_full, overflow_err, frame_valid, wr_ready);
      end
      send(0, NW, 8'hFF, 8'h00, 1'b0);
      tests_run++;
      if (frame_valid !== 1'b1 || banks_full !== 2'b01 || img_out[7:0] !== 8'hFF || img_out[903:896] !== 8'h0F) begin
         tests_failed++;
         $display("FAIL after_clear_frame: got fv=%b full=%b w0=%h w112=%h, expected 1 01 ff 0f",
                  frame_valid, banks_full, img_out[7:0], img_out[903:896]);
      end
   endtask

   task automatic test_msb_first_and_async_reset();
      for (int i = 0; i < NW; i++) begin
         b_data  = (i == 0) ? 8'h01 : ((i == 1) ? 8'h03 : 8'h00);
         b_valid = 1'b1;
         tick();
      end
      b_valid = 1'b0;
      tests_run++;
      if (b_frame_valid !== 1'b1 || b_img[7:0] !== 8'h80 || b_img[15:8] !== 8'hC0) begin
         tests_failed++;
         $display("FAIL msb_first: got fv=%b w0=%h w1=%h, expected 1 80 c0", b_frame_valid, b_img[7:0], b_img[15:8]);
      end
      for (int i = 0; i < 10; i++) begin
         b_data = 8'h5A; b_valid = 1'b1;
         data_in = 8'h11; wr_valid = 1'b1;
         tick();
      end
      tests_run++;
      if (b_count !== 7'd10 || wr_count !== 7'd10) begin
         tests_failed++;
         $display("FAIL mid_frame_count: got a=%0d b=%0d, expected 10 10", wr_count, b_count);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({wr_count, banks_full, frame_valid, wr_ready, overflow_err} !== {7'd0, 2'b00, 1'b0, 1'b1, 1'b0} ||
          {b_count, b_full, b_frame_valid, b_ready, b_ovf} !== {7'd0, 2'b00, 1'b0, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL async_reset: got a cnt=%0d full=%b fv=%b rdy=%b ovf=%b, b cnt=%0d full=%b fv=%b, expected zeros with rdy=1",
                  wr_count, banks_full, frame_valid, wr_ready, overflow_err, b_count, b_full, b_frame_valid);
      end
      wr_valid = 1'b0; b_valid = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_overflow();
      test_ack_when_full();
      test_ack_with_last();
      test_clear();
      test_msb_first_and_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pingpong_image_buffer.md
Name: pingpong_image_buffer

Overview:
Parametrised, double-buffered successor to the single-frame byte image buffer. It sits between the SPI/UART byte receiver and the BNN inference core. Incoming bytes fill one bank while the core reads a completed frame from the other bank. Write and read sides use valid/ready handshakes, so a new image can stream in during inference without corrupting the frame being classified.

Parameters:
IMG_WIDTH, 30, pixels per row
IMG_HEIGHT, 30, rows per frame
BYTE_W, 8, bits per input word
MSB_FIRST, 0, 1 = bit-reverse each word before storing (first pixel in word MSB)
TOTAL_BITS, IMG_WIDTH*IMG_HEIGHT (derived, localparam), valid pixel bits
NUM_WORDS, ceil(TOTAL_BITS/BYTE_W) (derived, localparam), words per frame (113 at defaults)
CNT_W, $clog2(NUM_WORDS+1) (derived, localparam), counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear_buffer  in  1  synchronous flush of both banks and all state
data_in  in  BYTE_W  input word
wr_valid  in  1  data_in is valid this cycle
wr_ready  out  1  buffer can accept a word this cycle
wr_count  out  CNT_W  words written into the current fill bank
frame_valid  out  1  a complete frame is presented on img_out
frame_ack  in  1  consumer releases the presented frame
img_out  out  NUM_WORDS*BYTE_W  flattened frame; word i at bits [i*BYTE_W +: BYTE_W]
banks_full  out  2  per-bank full flags (debug/status)
overflow_err  out  1  sticky: wr_valid seen while wr_ready=0

Behaviour:
- Reset (rst_n=0, async): wr_bank=0, rd_bank=0, wr_count=0, banks_full=2'b00, overflow_err=0, frame_valid=0, wr_ready=1. Bank contents are not reset. img_out is don't-care while frame_valid=0.
- State per bank: EMPTY or FULL (banks_full bit).
- Write FSM:
  - W_FILL: wr_ready=1. Entered when banks_full[wr_bank]=0.
  - W_STALL: wr_ready=0. Entered when both banks are FULL.
  - wr_ready is combinational: !banks_full[wr_bank].
- Accept: wr_valid & wr_ready. The word is stored at bank[wr_bank][wr_count], bit-reversed if MSB_FIRST, and wr_count increments.
- Accept of the last word (wr_count==NUM_WORDS-1), all in the same edge:
  - banks_full[wr_bank] <= 1
  - wr_count <= 0
  - wr_bank <= ~wr_bank
- Read side:
  - frame_valid = banks_full[rd_bank], driven from registers.
  - img_out = bank[rd_bank], with bits >= TOTAL_BITS forced to 0.
  - Latency: last word accepted at edge N, frame_valid=1 after edge N.
- frame_ack while frame_valid=1: banks_full[rd_bank] <= 0 and rd_bank <= ~rd_bank. frame_ack while frame_valid=0 is ignored.
- Simultaneous ack and last-word completion on different banks: both take effect. frame_valid stays 1 and img_out switches to the new bank.
- Both banks full, then ack: the freed bank equals wr_bank, so wr_ready=1 from the next cycle.
- overflow_err sets when wr_valid=1 and wr_ready=0. It clears only on rst_n or clear_buffer. The rejected word is dropped.
- clear_buffer (synchronous, highest priority after reset):
  - Same register values as reset.
  - Any write or ack in that cycle is ignored.
  - Mid-frame partial data is discarded.
- img_out must stay stable while frame_valid=1 and until ack. Writes never target rd_bank while it is FULL.

Decomposition:
- Shared package bnn_img_pkg holds: IMG_WIDTH, IMG_HEIGHT, BYTE_W defaults; the TOTAL_BITS/NUM_WORDS functions; typedef bank_state_e {EMPTY, FULL}; typedef wr_state_e {W_FILL, W_STALL}.
- One natural sub-module, image_bank: a NUM_WORDS x BYTE_W register array with write enable, address, data, and a flattened read output. It is instantiated twice; the top level holds the FSM, pointers and muxing.

Test Plan:
- Reset, then stream 113 words 0x00..0x70 with wr_valid held high. Required: wr_ready=1 throughout; frame_valid=1 one cycle after the 113th accept; img_out[7:0]=0x00; img_out[903:896]=0x70 with bits [903:900] forced 0.
- With frame 0 unacked, stream a second 113-word frame, then drive 5 more wr_valid. Required: banks_full=2'b11, wr_ready=0, overflow_err=1, wr_count=0, img_out still frame 0.
- Ack in that state. Required: frame_valid stays 1, img_out shows frame 1, and wr_ready=1 on the next cycle.
- Assert frame_ack on the same edge as the last word of a new frame (other bank). Required: the ack is honored, the new frame becomes valid, and banks_full ends with one bit set.
- Write 50 words, then pulse clear_buffer. Required: wr_count=0, banks_full=0, overflow_err=0, frame_valid=0. A following full frame completes normally.
- MSB_FIRST=1, write 0x01 as the first word. Required: img_out[7:0]=0x80. Assert rst_n low mid-frame: all outputs return to reset values asynchronously.
